// File: rtl/stats_pkg.sv
// Shared types and latency constants for the statistics-window scheduler.
package stats_pkg;

  typedef enum logic [3:0] {
    IDLE,
    CLEAR,
    WAIT_SAMPLE,
    ISSUE,
    SETTLE,
    COMPUTE,
    WAIT_RESULT,
    DONE,
    ERROR
  } state_e;

  // Cycles from an acc_valid_in pulse until the next sample may be accepted
  localparam int SAMPLE_LAT   = 6;
  localparam int VAR_LAT      = 4;
  localparam int CLEAR_CYCLES = 2;

endpackage

// File: rtl/stats_delay_timer.sv
// Loadable down-counter; expired_o rises on the load_val_i-th cycle after a load.
module stats_delay_timer #(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  output logic             expired_o
);

  logic [WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (count_q != '0) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired_o = (count_q <= WIDTH'(1));

endmodule

// File: rtl/stats_sched.sv
// Sequences sample windows into an external mean/variance accumulator:
// clear, feed N samples with settle gaps, request the variance, await the result.
module stats_sched
  import stats_pkg::*;
#(
  parameter int  SIGNED_BIT     = 1,
  parameter int  DATA_WIDTH     = 15,
  parameter int  FRAC_BITS      = 16,
  parameter int  MATRIX_SIZE    = 256,
  parameter int  MAX_SAMPLES    = 1024,
  parameter int  RESULT_TIMEOUT = 16,
  localparam int COUNT_WIDTH    = $clog2(MAX_SAMPLES) + 1,
  localparam int W              = SIGNED_BIT + DATA_WIDTH + FRAC_BITS
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   abort,
  input  logic [COUNT_WIDTH-1:0] cfg_num_samples,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic signed [W-1:0]    s_data [MATRIX_SIZE],
  output logic                   acc_rst_n,
  output logic                   acc_valid_in,
  output logic signed [W-1:0]    acc_x_matrix [MATRIX_SIZE],
  output logic                   acc_compute_variance,
  input  logic                   acc_valid_out,
  output logic                   busy,
  output logic                   done,
  output logic                   err,
  output logic [COUNT_WIDTH-1:0] samples_done
);

  localparam int TMR_MAX = (RESULT_TIMEOUT > SAMPLE_LAT) ? RESULT_TIMEOUT : SAMPLE_LAT;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);

  state_e                 state_q, state_d;
  logic [COUNT_WIDTH-1:0] n_q, n_d;
  logic [COUNT_WIDTH-1:0] samples_done_q, samples_done_d;
  logic [1:0]             clr_cnt_q, clr_cnt_d;
  logic                   acc_rst_n_q, acc_rst_n_d;
  logic                   acc_valid_in_q, acc_valid_in_d;
  logic                   acc_cv_q, acc_cv_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   err_q, err_d;
  logic signed [W-1:0]    acc_x_q [MATRIX_SIZE];

  logic                   cfg_ok;
  logic                   start_ok;
  logic                   handshake;
  logic                   last_sample;
  logic                   settle_end;
  logic                   tmr_load;
  logic [TMR_W-1:0]       tmr_load_val;
  logic                   tmr_expired;

  assign cfg_ok      = (cfg_num_samples >= COUNT_WIDTH'(2)) &&
                       (cfg_num_samples <= COUNT_WIDTH'(MAX_SAMPLES));
  assign start_ok    = (state_q == IDLE) && start && cfg_ok && !abort;
  assign s_ready     = (state_q == WAIT_SAMPLE);
  assign handshake   = s_valid && s_ready && !abort;
  assign last_sample = ((samples_done_q + COUNT_WIDTH'(1)) >= n_q);
  assign settle_end  = (state_q == SETTLE) && tmr_expired && !abort;

  // One timer covers both the post-issue settle gap and the result timeout
  assign tmr_load     = (state_q == ISSUE) || (state_q == COMPUTE);
  assign tmr_load_val = (state_q == COMPUTE) ? TMR_W'(RESULT_TIMEOUT) : TMR_W'(SAMPLE_LAT - 1);

  stats_delay_timer #(
    .WIDTH (TMR_W)
  ) u_timer (
    .clk        (clk),
    .rst        (rst),
    .load_i     (tmr_load),
    .load_val_i (tmr_load_val),
    .expired_o  (tmr_expired)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:        if (start) state_d = cfg_ok ? CLEAR : ERROR;
      CLEAR:       if (clr_cnt_q == 2'(CLEAR_CYCLES - 1)) state_d = WAIT_SAMPLE;
      WAIT_SAMPLE: if (s_valid) state_d = ISSUE;
      ISSUE:       state_d = SETTLE;
      SETTLE:      if (tmr_expired) state_d = last_sample ? COMPUTE : WAIT_SAMPLE;
      COMPUTE:     state_d = WAIT_RESULT;
      WAIT_RESULT: begin
        if (acc_valid_out) begin
          state_d = DONE;
        end else if (tmr_expired) begin
          state_d = ERROR;
        end
      end
      DONE:        state_d = IDLE;
      ERROR:       state_d = IDLE;
      default:     state_d = IDLE;
    endcase
    if (abort) begin
      state_d = IDLE;
    end
  end

  // Outputs are registered from the next state so they line up with it
  always_comb begin
    acc_rst_n_d    = (state_d != CLEAR);
    acc_valid_in_d = (state_d == ISSUE);
    acc_cv_d       = (state_d == COMPUTE);
    busy_d         = (state_d != IDLE);
    done_d         = (state_d == DONE);
    err_d          = err_q;
    if (start_ok) begin
      err_d = 1'b0;
    end
    if (state_d == ERROR) begin
      err_d = 1'b1;
    end
    n_d            = start_ok ? cfg_num_samples : n_q;
    clr_cnt_d      = (state_q == CLEAR) ? clr_cnt_q + 2'd1 : 2'd0;
    samples_done_d = samples_done_q;
    if (start_ok) begin
      samples_done_d = '0;
    end else if (settle_end && (samples_done_q < n_q)) begin
      samples_done_d = samples_done_q + COUNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      n_q            <= '0;
      samples_done_q <= '0;
      clr_cnt_q      <= '0;
      acc_rst_n_q    <= 1'b0;
      acc_valid_in_q <= 1'b0;
      acc_cv_q       <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      err_q          <= 1'b0;
    end else begin
      state_q        <= state_d;
      n_q            <= n_d;
      samples_done_q <= samples_done_d;
      clr_cnt_q      <= clr_cnt_d;
      acc_rst_n_q    <= acc_rst_n_d;
      acc_valid_in_q <= acc_valid_in_d;
      acc_cv_q       <= acc_cv_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
      err_q          <= err_d;
    end
  end

  // Sample hold register stays frozen from the handshake until the next one
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < MATRIX_SIZE; i++) begin
        acc_x_q[i] <= '0;
      end
    end else if (handshake) begin
      for (int i = 0; i < MATRIX_SIZE; i++) begin
        acc_x_q[i] <= s_data[i];
      end
    end
  end

  assign acc_rst_n            = acc_rst_n_q;
  assign acc_valid_in         = acc_valid_in_q;
  assign acc_compute_variance = acc_cv_q;
  assign acc_x_matrix         = acc_x_q;
  assign busy                 = busy_q;
  assign done                 = done_q;
  assign err                  = err_q;
  assign samples_done         = samples_done_q;

endmodule

// File: tb/tb_stats_sched.sv
// Directed bench for stats_sched with a small column-0 mean/variance accumulator model.
module tb_stats_sched;
  import stats_pkg::*;

  localparam int MS   = 4;
  localparam int MAXS = 1024;
  localparam int RT   = 16;
  localparam int CW   = $clog2(MAXS) + 1;
  localparam int W    = 32;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                start = 1'b0;
  logic                abort = 1'b0;
  logic [CW-1:0]       cfg_num_samples = '0;
  logic                s_valid = 1'b0;
  logic                s_ready;
  logic signed [W-1:0] s_data [MS];
  logic                acc_rst_n;
  logic                acc_valid_in;
  logic signed [W-1:0] acc_x_matrix [MS];
  logic                acc_compute_variance;
  logic                acc_valid_out = 1'b0;
  logic                busy;
  logic                done;
  logic                err;
  logic [CW-1:0]       samples_done;

  stats_sched #(
    .SIGNED_BIT     (1),
    .DATA_WIDTH     (15),
    .FRAC_BITS      (16),
    .MATRIX_SIZE    (MS),
    .MAX_SAMPLES    (MAXS),
    .RESULT_TIMEOUT (RT)
  ) dut (
    .clk                  (clk),
    .rst                  (rst),
    .start                (start),
    .abort                (abort),
    .cfg_num_samples      (cfg_num_samples),
    .s_valid              (s_valid),
    .s_ready              (s_ready),
    .s_data               (s_data),
    .acc_rst_n            (acc_rst_n),
    .acc_valid_in         (acc_valid_in),
    .acc_x_matrix         (acc_x_matrix),
    .acc_compute_variance (acc_compute_variance),
    .acc_valid_out        (acc_valid_out),
    .busy                 (busy),
    .done                 (done),
    .err                  (err),
    .samples_done         (samples_done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errs   = 0;
  int cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Accumulator model: column 0 only, sample variance (divide by N-1), Q16.16
  logic   acc_en = 1'b1;
  longint sum = 0, sumsq = 0, mean_r = 0, var_r = 0;
  int     cnt = 0, var_cd = 0;

  always @(posedge clk) begin
    acc_valid_out <= 1'b0;
    if (!acc_rst_n) begin
      sum <= 0; sumsq <= 0; cnt <= 0; var_cd <= 0; mean_r <= -1; var_r <= -1;
    end else begin
      if (acc_valid_in) begin
        sum   <= sum + longint'(acc_x_matrix[0]);
        sumsq <= sumsq + longint'(acc_x_matrix[0]) * longint'(acc_x_matrix[0]);
        cnt   <= cnt + 1;
      end
      if (acc_compute_variance) begin
        var_cd <= VAR_LAT;
      end else if (var_cd > 0) begin
        var_cd <= var_cd - 1;
        if (var_cd == 1 && cnt > 1) begin
          mean_r        <= sum / longint'(cnt);
          var_r         <= ((sumsq - (sum * sum) / longint'(cnt)) / longint'(cnt - 1)) >>> 16;
          acc_valid_out <= acc_en;
        end
      end
    end
  end

  // Event monitor; only this process writes these counters
  int vin_cnt = 0, cmp_cnt = 0, done_cnt = 0, rdy_cnt = 0, rstn_low = 0;
  int gap_err = 0, x_unstable = 0, overlap = 0;
  int last_vin = -1, cmp_cyc = -1, err_rise = -1, settle_left = 0;
  logic signed [W-1:0] hold_x = '0;
  logic err_prev = 1'b0;

  always @(negedge clk) begin
    if (!busy) last_vin = -1;
    if (acc_valid_in) begin
      vin_cnt++;
      if (last_vin >= 0 && (cyc - last_vin) != 7) gap_err++;
      last_vin    = cyc;
      hold_x      = acc_x_matrix[0];
      settle_left = 5;
    end else if (settle_left > 0) begin
      if (acc_x_matrix[0] !== hold_x) x_unstable++;
      settle_left--;
    end
    if (acc_compute_variance) begin cmp_cnt++; cmp_cyc = cyc; end
    if (acc_valid_in && acc_compute_variance) overlap++;
    if (done) done_cnt++;
    if (s_ready) rdy_cnt++;
    if (!acc_rst_n && !rst) rstn_low++;
    if (err && !err_prev) err_rise = cyc;
    err_prev = err;
  end

  int b_vin, b_cmp, b_done, b_rdy, b_rstn;

  task automatic snap();
    b_vin = vin_cnt; b_cmp = cmp_cnt; b_done = done_cnt; b_rdy = rdy_cnt; b_rstn = rstn_low;
  endtask

  task automatic check_eq(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_window(input int n);
    cfg_num_samples = CW'(n);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  logic signed [W-1:0] feed_vals [8];

  task automatic feed_window(input int n);
    bit ok;
    s_valid = 1'b1;
    for (int k = 0; k < n; k++) begin
      s_data[0] = feed_vals[k];
      ok = 1'b0;
      for (int i = 0; i < 40; i++) begin
        if (s_ready) begin ok = 1'b1; break; end
        tick();
      end
      if (!ok) begin
        check_eq("sready_wait", 0, 1);
        break;
      end
      tick();
      // scramble upstream data while the hold register must stay put
      s_data[0] = 32'sh7FFF0000;
    end
  endtask

  task automatic wait_end(input string tag);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (done_cnt != b_done || err) begin ok = 1'b1; break; end
      tick();
    end
    if (!ok) check_eq(tag, 0, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < MS; i++) s_data[i] = 32'(i * 32'h1000);

    // Reset state
    tick(); tick();
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_err", err, 0);
    check_eq("rst_acc_rst_n", acc_rst_n, 0);
    check_eq("rst_samples", samples_done, 0);
    check_eq("rst_sready", s_ready, 0);
    check_eq("rst_x0", acc_x_matrix[0], 0);
    rst = 1'b0;
    #1;
    check_eq("rst_rel_rstn_low", acc_rst_n, 0);
    tick();
    check_eq("rst_rel_rstn_high", acc_rst_n, 1);
    tick();

    // Nominal window, N=4, s_valid held high throughout
    feed_vals[0] = 32'sh00010000; feed_vals[1] = 32'sh00040000;
    feed_vals[2] = 32'sh00070000; feed_vals[3] = 32'sh000A0000;
    snap();
    start_window(4);
    check_eq("nom_busy", busy, 1);
    feed_window(4);
    wait_end("nom_end_timeout");
    tick(); tick();
    s_valid = 1'b0;
    check_eq("nom_vin_pulses", vin_cnt - b_vin, 4);
    check_eq("nom_vin_gap7", gap_err, 0);
    check_eq("nom_cmp_pulses", cmp_cnt - b_cmp, 1);
    check_eq("nom_done_pulses", done_cnt - b_done, 1);
    check_eq("nom_rdy_cycles", rdy_cnt - b_rdy, 4);
    check_eq("nom_x_stable", x_unstable, 0);
    check_eq("nom_overlap", overlap, 0);
    check_eq("nom_err", err, 0);
    check_eq("nom_busy_end", busy, 0);
    check_eq("nom_samples", samples_done, 4);
    check_eq("nom_mean0", mean_r, 64'h58000);
    check_eq("nom_var0", var_r, 64'hF0000);

    // Bad configurations
    snap();
    start_window(1);
    tick();
    check_eq("bad1_err", err, 1);
    check_eq("bad1_busy", busy, 0);
    start_window(MAXS + 1);
    tick();
    check_eq("badmax_err", err, 1);
    check_eq("badmax_busy", busy, 0);
    check_eq("bad_no_vin", vin_cnt - b_vin, 0);
    check_eq("bad_no_rstn", rstn_low - b_rstn, 0);

    // Result timeout
    acc_en = 1'b0;
    feed_vals[0] = 32'sh00010000; feed_vals[1] = 32'sh00030000;
    snap();
    start_window(2);
    check_eq("to_err_cleared", err, 0);
    feed_window(2);
    s_valid = 1'b0;
    wait_end("to_end_timeout");
    tick();
    check_eq("to_err", err, 1);
    check_eq("to_latency", err_rise - cmp_cyc, RT + 1);
    check_eq("to_no_done", done_cnt - b_done, 0);
    check_eq("to_busy", busy, 0);
    acc_en = 1'b1;

    // Abort during SETTLE after sample 2, then a fresh N=2 window
    snap();
    start_window(4);
    feed_window(2);
    s_valid = 1'b0;
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check_eq("ab_busy", busy, 0);
    tick(); tick();
    check_eq("ab_vin", vin_cnt - b_vin, 2);
    check_eq("ab_no_cmp", cmp_cnt - b_cmp, 0);
    check_eq("ab_no_err", err, 0);
    check_eq("ab_no_done", done_cnt - b_done, 0);
    feed_vals[0] = 32'sh00020000; feed_vals[1] = 32'sh00040000;
    snap();
    start_window(2);
    feed_window(2);
    s_valid = 1'b0;
    wait_end("ab2_end_timeout");
    tick();
    check_eq("ab2_rstn_low", rstn_low - b_rstn, 2);
    check_eq("ab2_done", done_cnt - b_done, 1);
    check_eq("ab2_mean0", mean_r, 64'h30000);
    check_eq("ab2_var0", var_r, 64'h20000);
    check_eq("ab2_samples", samples_done, 2);

    // Asynchronous reset in the middle of SETTLE
    snap();
    start_window(2);
    feed_window(1);
    s_valid = 1'b0;
    tick();
    #2;
    rst = 1'b1;
    #1;
    check_eq("ar_busy", busy, 0);
    check_eq("ar_rstn", acc_rst_n, 0);
    check_eq("ar_vin", acc_valid_in, 0);
    check_eq("ar_cmp", acc_compute_variance, 0);
    check_eq("ar_samples", samples_done, 0);
    check_eq("ar_x0", acc_x_matrix[0], 0);
    check_eq("ar_err", err, 0);
    tick();
    rst = 1'b0;
    #1;
    check_eq("ar_rel_rstn_low", acc_rst_n, 0);
    tick();
    check_eq("ar_rel_rstn_high", acc_rst_n, 1);
    tick(); tick();
    check_eq("ar_no_done", done_cnt - b_done, 0);
    check_eq("ar_no_err_after", err, 0);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule

// File: doc/stats_sched.md
STATS_SCHED -- requirements
Module: stats_sched

Interface
REQ-001 SHALL have parameter SIGNED_BIT, default 1, sign bit count of each sample element.
REQ-002 SHALL have parameter DATA_WIDTH, default 15, integer bits per element.
REQ-003 SHALL have parameter FRAC_BITS, default 16, fractional bits per element.
REQ-004 SHALL have parameter MATRIX_SIZE, default 256, elements per sample vector.
REQ-005 SHALL have parameter MAX_SAMPLES, default 1024, maximum window length.
REQ-006 SHALL have parameter RESULT_TIMEOUT, default 16, cycles allowed for the variance result to return.
REQ-007 SHALL derive COUNT_WIDTH = $clog2(MAX_SAMPLES)+1 and W = SIGNED_BIT+DATA_WIDTH+FRAC_BITS.
REQ-008 SHALL have port clk, input, 1, single clock.
REQ-009 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-010 SHALL have port start, input, 1, one-cycle pulse that begins a window.
REQ-011 SHALL have port abort, input, 1, cancels the current window.
REQ-012 SHALL have port cfg_num_samples, input, COUNT_WIDTH, window length N.
REQ-013 SHALL have ports s_valid (input, 1), s_ready (output, 1) and s_data (input, signed W x MATRIX_SIZE array), the upstream sample stream.
REQ-014 SHALL have ports acc_rst_n (output, 1), acc_valid_in (output, 1), acc_x_matrix (output, signed W x MATRIX_SIZE), acc_compute_variance (output, 1) and acc_valid_out (input, 1), the accumulator control.
REQ-015 SHALL have ports busy (output, 1), done (output, 1, one-cycle pulse), err (output, 1, sticky) and samples_done (output, COUNT_WIDTH).

Function
REQ-016 SHALL implement an FSM with states IDLE, CLEAR, WAIT_SAMPLE, ISSUE, SETTLE, COMPUTE, WAIT_RESULT, DONE and ERROR.
REQ-017 IDLE: on start with 2<=cfg_num_samples<=MAX_SAMPLES, SHALL latch N, clear err and samples_done, and go to CLEAR; on start with any other N, SHALL go to ERROR.
REQ-018 CLEAR: SHALL drive acc_rst_n=0 for exactly 2 cycles, then go to WAIT_SAMPLE.
REQ-019 WAIT_SAMPLE: s_ready SHALL be 1 only in this state and SHALL be combinational from state; a handshake (s_valid & s_ready) SHALL capture s_data into the acc_x_matrix hold register and go to ISSUE.
REQ-020 ISSUE: acc_valid_in SHALL be 1 for exactly this one cycle, one cycle after the handshake.
REQ-021 SETTLE: acc_x_matrix SHALL be held stable and SETTLE SHALL last 5 cycles, so s_ready reasserts 6 cycles after the acc_valid_in pulse.
REQ-022 At SETTLE exit, samples_done SHALL increment; if samples_done then equals N the FSM SHALL go to COMPUTE, otherwise to WAIT_SAMPLE.
REQ-023 COMPUTE: acc_compute_variance SHALL be 1 for exactly one cycle, then the FSM SHALL go to WAIT_RESULT with the timeout counter loaded to RESULT_TIMEOUT.
REQ-024 WAIT_RESULT: acc_valid_out=1 SHALL go to DONE; timeout expiry SHALL go to ERROR; if both occur in the same cycle, acc_valid_out SHALL win.
REQ-025 DONE: done SHALL be 1 for one cycle, then the FSM SHALL go to IDLE; accumulator results SHALL remain valid until the next start.
REQ-026 ERROR: SHALL set err=1 and go to IDLE next cycle; err SHALL hold until the next accepted start.
REQ-027 busy SHALL be 1 in every state except IDLE.
REQ-028 start SHALL be ignored while busy=1.
REQ-029 abort SHALL force IDLE on the next cycle from any state, SHALL take priority over every other event, SHALL NOT set err, and SHALL NOT issue further acc pulses.
REQ-030 acc_valid_in and acc_compute_variance SHALL never both be 1 in the same cycle.
REQ-031 Every output except s_ready SHALL be registered.
REQ-032 samples_done SHALL saturate at N.

Reset
REQ-033 While rst=1: state=IDLE, acc_rst_n=0, acc_valid_in=0, acc_compute_variance=0, acc_x_matrix=0, busy=0, done=0, err=0, samples_done=0.
REQ-034 acc_rst_n SHALL go to 1 on the first clock edge after rst deasserts.
REQ-035 Reset asserted mid-window SHALL immediately abandon the window, with no done and no err.

Structure
REQ-036 Package stats_pkg SHALL hold the state enum, SAMPLE_LAT=6, VAR_LAT=4 and CLEAR_CYCLES=2.
REQ-037 A single sub-module, stats_delay_timer (loadable down-counter with an expiry flag), SHALL serve both SETTLE and WAIT_RESULT.

Verification
REQ-038 Nominal window: N=4, column 0 fed 1.0, 4.0, 7.0, 10.0 (0x00010000 ...) into a real accumulator -> exactly 4 acc_valid_in pulses, each 7 cycles apart; 1 compute pulse; done; mean[0]=0x00058000 and variance[0]=0x000F0000, each within ±4 LSB.
REQ-039 Backpressure: s_valid held high throughout -> s_ready high exactly 1 cycle per sample, and acc_x_matrix stable through SETTLE.
REQ-040 Bad config: start with N=1, and again with N=MAX_SAMPLES+1 -> err=1 after 2 cycles, busy low, no acc pulses.
REQ-041 Timeout: acc_valid_out tied to 0 -> err asserted RESULT_TIMEOUT+1 cycles after the compute pulse, with no done.
REQ-042 Abort in SETTLE after sample 2 -> IDLE next cycle; a following start with N=2 gives a 2-cycle acc_rst_n low pulse and fresh statistics.
REQ-043 Async rst pulse mid-SETTLE -> all outputs at reset values within the same cycle; acc_rst_n low until the first edge after release.
